// File: rtl/simon_core_arbiter.sv
// simon_core_arbiter: two-port round-robin front end sharing one SIMON 128/128 core with per-port shadow keys.
// Defining SIMON_ARB_WDOG_EN adds a newData-to-doneData watchdog that aborts stuck operations.
module simon_core_arbiter #(
  parameter int N           = 64,
  parameter int M           = 2,
  parameter int WDOG_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  nR,
  input  logic [1:0]            key_wr,
  input  logic [1:0][M*N-1:0]   key_in,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_enc_dec,
  input  logic [1:0][2*N-1:0]   req_data,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [1:0][2*N-1:0]   rsp_data,
  output logic [1:0]            rsp_err,
  output logic                  core_newKey,
  output logic                  core_newData,
  output logic                  core_readData,
  output logic                  core_enc_dec,
  output logic [M*N-1:0]        core_key,
  output logic [2*N-1:0]        core_plain,
  input  logic                  core_ldKey,
  input  logic                  core_ldData,
  input  logic                  core_doneKey,
  input  logic                  core_doneData,
  input  logic [2*N-1:0]        core_cipher
);
  typedef enum logic [2:0] {
    IDLE, GRANT, KEY_LD, KEY_WT, DATA_LD, DATA_WT, READ
`ifdef SIMON_ARB_WDOG_EN
    , ABORT
`endif
  } state_t;
  state_t state_q, state_d;
  logic [1:0] pending_q, pending_d, mode_q, mode_d, rsp_valid_q, rsp_valid_d, sched;
  logic [1:0][2*N-1:0] buf_q, buf_d, rsp_data_q, rsp_data_d;
  logic [1:0][M*N-1:0] shadow_q, shadow_d;
  logic owner_q, owner_d, owner_valid_q, owner_valid_d, last_grant_q, last_grant_d;
  logic grant_q, grant_d, stale_q, stale_d;
`ifdef SIMON_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic [1:0] rsp_err_q, rsp_err_d;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = '0;
`endif
  assign sched        = pending_q & ~rsp_valid_q;
  assign req_ready    = ~pending_q & ~rsp_valid_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign core_key     = shadow_q[grant_q];
  assign core_plain   = buf_q[grant_q];
  assign core_enc_dec = mode_q[grant_q];
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    mode_d        = mode_q;
    buf_d         = buf_q;
    shadow_d      = shadow_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    stale_d       = stale_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    core_newKey   = 1'b0;
    core_newData  = 1'b0;
    core_readData = 1'b0;
`ifdef SIMON_ARB_WDOG_EN
    wdog_d        = wdog_q;
    rsp_err_d     = rsp_err_q;
`endif
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        pending_d[i] = 1'b1;
        mode_d[i]    = req_enc_dec[i];
        buf_d[i]     = req_data[i];
      end
      if (rsp_valid_q[i] && rsp_ready[i]) begin
        pending_d[i]   = 1'b0;
        rsp_valid_d[i] = 1'b0;
`ifdef SIMON_ARB_WDOG_EN
        rsp_err_d[i]   = 1'b0;
`endif
      end
      if (key_wr[i]) begin
        shadow_d[i] = key_in[i];
        if (owner_q == i[0]) owner_valid_d = 1'b0;
      end
    end
    case (state_q)
      IDLE: state_d = |sched ? GRANT : IDLE;
      GRANT: begin
        grant_d      = &sched ? !last_grant_q : sched[1];
        last_grant_d = grant_d;
        stale_d      = 1'b0;
        state_d      = (owner_valid_d && owner_q == grant_d) ? DATA_LD : KEY_LD;
      end
      KEY_LD: if (core_ldKey) begin
        core_newKey = 1'b1;
        stale_d     = key_wr[grant_q];
        state_d     = KEY_WT;
      end
      // a shadow write during expansion means the core holds an outdated key
      KEY_WT: begin
        stale_d = stale_q | key_wr[grant_q];
        if (core_doneKey) begin
          owner_d       = grant_q;
          owner_valid_d = !(stale_q | key_wr[grant_q]);
          state_d       = DATA_LD;
        end
      end
      DATA_LD: if (core_ldData && core_doneKey) begin
        core_newData = 1'b1;
        state_d      = DATA_WT;
`ifdef SIMON_ARB_WDOG_EN
        wdog_d       = '0;
`endif
      end
      DATA_WT: begin
        if (core_doneData) state_d = READ;
`ifdef SIMON_ARB_WDOG_EN
        else if (wdog_q == WW'(WDOG_CYCLES - 2)) state_d = ABORT;
        else wdog_d = wdog_q + 1'b1;
`endif
      end
      READ: begin
        core_readData           = 1'b1;
        rsp_data_d[grant_q]     = core_cipher;
        rsp_valid_d[grant_q]    = 1'b1;
        state_d                 = IDLE;
      end
`ifdef SIMON_ARB_WDOG_EN
      ABORT: begin
        rsp_data_d[grant_q]  = '0;
        rsp_err_d[grant_q]   = 1'b1;
        rsp_valid_d[grant_q] = 1'b1;
        owner_valid_d        = 1'b0;
        state_d              = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      mode_q        <= '0;
      buf_q         <= '0;
      shadow_q      <= '0;
      owner_q       <= 1'b0;
      owner_valid_q <= 1'b0;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      stale_q       <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
`ifdef SIMON_ARB_WDOG_EN
      wdog_q        <= '0;
      rsp_err_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      mode_q        <= mode_d;
      buf_q         <= buf_d;
      shadow_q      <= shadow_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      stale_q       <= stale_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
`ifdef SIMON_ARB_WDOG_EN
      wdog_q        <= wdog_d;
      rsp_err_q     <= rsp_err_d;
`endif
    end
  end
endmodule

// File: doc/simon_core_arbiter.md
Name: simon_core_arbiter

Overview:
- Shares one SIMON 128/128 core (clk/nR, newData/newKey/ldData/ldKey/doneData/doneKey/readData handshake) between two requesters.
- Each requester owns a shadow key. The arbiter schedules requests round-robin and reloads the core key only when the granted requester is not the current key owner.
- It drives the core's key-load, data-load and readout handshakes and returns results on per-port response channels.

Parameters:
- N, 64, word width; block = 2*N bits.
- M, 2, key words; key = M*N bits.
- WDOG_CYCLES, 255, cycles allowed from newData to doneData (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge
- nR  in  1  asynchronous active-low reset
- key_wr  in  2  per-port pulse; loads key_in[i] into shadow key i
- key_in  in  2x(M*N)  per-port key
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request ready
- req_enc_dec  in  2  per-port mode: 1 = encrypt, 0 = decrypt
- req_data  in  2x(2*N)  per-port input block
- rsp_valid  out  2  per-port response valid
- rsp_ready  in  2  per-port response ready
- rsp_data  out  2x(2*N)  per-port result block
- rsp_err  out  2  per-port watchdog abort flag (0 when the optional feature is off)
- core_newKey, core_newData, core_readData, core_enc_dec  out  1 each  core controls
- core_key  out  M*N  key to core
- core_plain  out  2*N  block to core
- core_ldKey, core_ldData, core_doneKey, core_doneData  in  1 each  core status
- core_cipher  in  2*N  core result

Behaviour:
- Core contract:
  - newKey is a 1-cycle pulse, issued only while ldKey=1.
  - doneKey rises when key expansion finishes.
  - newData is a 1-cycle pulse, issued only while ldData=1 and doneKey=1.
  - doneData stays high until readData. core_cipher is sampled in the cycle readData pulses.
- Reset values:
  - All outputs 0, except req_ready = 2'b11.
  - pending = 0, owner_valid = 0, last_grant = 1.
  - State = IDLE.
- Request capture:
  - A handshake on port i (req_valid & req_ready) latches mode and block into a one-entry buffer and sets pending[i].
  - req_ready[i] = !pending[i] & !rsp_valid[i].
- States:
  - IDLE: if any pending, go to GRANT.
  - GRANT (1 cycle):
    - Pick g. If both ports are pending, g = !last_grant; otherwise g = the pending port.
    - last_grant <= g.
    - If owner_valid && owner == g, go to DATA_LD; otherwise go to KEY_LD.
  - KEY_LD: wait for ldKey; pulse newKey with shadow key g; go to KEY_WT.
  - KEY_WT: on doneKey, set owner = g and owner_valid = 1; go to DATA_LD.
  - DATA_LD: wait for ldData; pulse newData with buffered block and mode; go to DATA_WT.
  - DATA_WT: on doneData, go to READ.
  - READ (1 cycle): pulse readData; capture core_cipher into rsp_data[g]; set rsp_valid[g] next cycle; go to IDLE.
- Response:
  - rsp_valid[i] holds, with rsp_data stable, until rsp_ready[i].
  - On the rsp handshake, pending[i] and rsp_valid[i] clear.
  - The other port may be scheduled while a response waits.
- key_wr[i]:
  - Updates shadow key i.
  - If i == owner, clears owner_valid in the same cycle. This holds even mid-operation; the current operation completes with the already-expanded key.
  - key_wr in the same cycle as the newKey pulse: the core gets the old shadow value and owner_valid stays 0, so the key reloads at the next grant.
- Simultaneous new request on the just-served port plus a pending other port: round-robin serves the other port first.
- Latency, clean key: req handshake → rsp_valid = 1 (capture) + 1 (IDLE) + 1 (GRANT) + ldData wait + core time + 1 (READ) + 1.
- Latency, key reload: adds KEY_LD/KEY_WT and the expansion time.
- nR low at any time: immediate return to reset values. Buffered requests are lost. owner_valid = 0 forces a key reload afterwards.

Optional Feature:
- Macro: SIMON_ARB_WDOG_EN.
- Defined:
  - A counter starts at the newData pulse.
  - If doneData is not seen within WDOG_CYCLES, go to ABORT (1 cycle).
  - ABORT: rsp_err[g] = 1, rsp_data[g] = 0, rsp_valid[g] = 1, owner_valid = 0.
  - rsp_err clears with the response handshake.
- Undefined: no counter and no ABORT state; rsp_err is tied 0; DATA_WT waits indefinitely.

Test Plan:
- Port0 key_in = 0x0f0e0d0c0b0a0908_0706050403020100, enc, data = 0x63736564207372656c6c657661727420 → exactly one newKey then one newData; rsp_data[0] = 0x49681b1e1e54fe3f65aa832af84e0bbc; rsp_err = 0.
- Repeat the port0 request with the key unchanged → no newKey pulse; same ciphertext.
- Port0 decrypt of 0x49681b1e1e54fe3f65aa832af84e0bbc → rsp_data[0] = 0x63736564207372656c6c657661727420.
- Both ports request in the same cycle, port1 with a different key, after reset → port0 is served first, then port1; newKey is pulsed before each grant (ownership changes); grants alternate 0,1,0,1 over 4 back-to-back requests.
- key_wr[0] during port0 DATA_WT → current result uses the old key; the next port0 request reloads the key.
- With SIMON_ARB_WDOG_EN and a core model that never raises doneData, WDOG_CYCLES = 16 → rsp_valid = 1 and rsp_err = 1 on the 17th cycle after newData; the next request pulses newKey.
- nR low for 1 cycle in KEY_WT → all outputs return to reset values; req_ready = 2'b11.
